ldm_stm_sequencer: RTL

Multi-register transfer sequencer for the pipelined Thumb core's memory stage. It takes one LDM, STM, PUSH or POP and drives one word access per cycle into `data_mem` through its `mem_write_en` / `opCode` / `mem_addr` / `mem_data_in` / `mem_data_out` port. It collects load data returned one cycle later and writes it back to the register file, then writes back the base register. It sits between the execute/memory pipeline register and `data_mem`, and stalls the pipeline while busy.

---
 rtl/ldm_stm_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ldm_stm_sequencer.sv
// ============================================================================
// Module   : ldm_stm_sequencer
// Function : LDM/STM/PUSH/POP sequencer issuing one word access per cycle,
//            with load writeback and base writeback. Optional macro:
//            POP_PC_FLUSH_EN (pulse flush_req when a POP writes r15).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ldm_stm_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [8:0]        reg_list,
   input  logic [2:0]        base_reg,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_write_en,
   output logic [6:0]        mem_op,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [3:0]        rf_rd_addr,
   input  logic [31:0]       rf_rd_data,
   output logic              rf_wr_en,
   output logic [3:0]        rf_wr_addr,
   output logic [31:0]       rf_wr_data,
   output logic              flush_req
);

   localparam logic [1:0] c_op_stm  = 2'd0;
   localparam logic [1:0] c_op_ldm  = 2'd1;
   localparam logic [1:0] c_op_push = 2'd2;
   localparam logic [1:0] c_op_pop  = 2'd3;
   localparam logic [ADDR_W-1:0] c_word = ADDR_W'(4);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_BASE_WB} state_t;

   state_t             r_state, w_state_nxt;
   logic [1:0]         r_op;
   logic [8:0]         r_mask;
   logic [ADDR_W-1:0]  r_addr, r_final_base;
   logic [2:0]         r_base_reg;
   logic               r_base_in_list;
   logic               r_ld_valid;
   logic [3:0]         r_ld_idx;

   logic [8:0]         w_mask_in;
   logic [3:0]         w_count;
   logic [ADDR_W-1:0]  w_offset;
   logic [3:0]         w_sel_bit;
   logic [3:0]         w_sel_reg;
   logic               w_is_load;
   logic               w_last;
   logic               w_issue_load;
   logic               w_done;

   // LR/PC slot only exists for PUSH/POP
   assign w_mask_in = op[1] ? reg_list : {1'b0, reg_list[7:0]};
   assign w_offset  = ADDR_W'({w_count, 2'b00});
   assign w_is_load = r_op[0];
   assign w_last    = (r_mask & (r_mask - 9'd1)) == 9'd0;
   assign w_issue_load = (r_state == S_XFER) && (r_mask != 9'd0) && w_is_load;
   assign w_sel_reg = (w_sel_bit == 4'd8) ? ((r_op == c_op_push) ? 4'd14 : 4'd15) : w_sel_bit;

   always_comb begin
      w_count = 4'd0;
      for (int i = 0; i < 9; i++) w_count = w_count + {3'b000, w_mask_in[i]};
   end

   always_comb begin
      w_sel_bit = 4'd0;
      for (int i = 8; i >= 0; i--) if (r_mask[i]) w_sel_bit = 4'(i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_op           <= c_op_stm;
         r_mask         <= 9'd0;
         r_addr         <= '0;
         r_final_base   <= '0;
         r_base_reg     <= 3'd0;
         r_base_in_list <= 1'b0;
         r_ld_valid     <= 1'b0;
         r_ld_idx       <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_ld_valid <= w_issue_load;
         if (w_issue_load) r_ld_idx <= w_sel_reg;
         if (r_state == S_IDLE && start) begin
            r_op           <= op;
            r_mask         <= w_mask_in;
            r_addr         <= (op == c_op_push) ? base_addr - w_offset : base_addr;
            r_final_base   <= (op == c_op_push) ? base_addr - w_offset : base_addr + w_offset;
            r_base_reg     <= base_reg;
            r_base_in_list <= (op == c_op_ldm) && reg_list[base_reg];
         end else if (r_state == S_XFER && r_mask != 9'd0) begin
            r_mask <= r_mask & (r_mask - 9'd1);
            r_addr <= r_addr + c_word;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      busy         = 1'b0;
      w_done       = 1'b0;
      mem_write_en = 1'b0;
      mem_op       = 7'd0;
      mem_addr     = '0;
      mem_wdata    = 32'd0;
      rf_rd_addr   = 4'd0;
      rf_wr_en     = r_ld_valid;
      rf_wr_addr   = r_ld_valid ? r_ld_idx : 4'd0;
      rf_wr_data   = r_ld_valid ? mem_rdata : 32'd0;
      if (r_state != S_IDLE) begin
         busy = 1'b1;
         case (r_op)
            c_op_stm:  mem_op = 7'b1100_000;
            c_op_ldm:  mem_op = 7'b1100_100;
            c_op_push: mem_op = 7'b1011_010;
            default:   mem_op = 7'b1011_110;
         endcase
      end
      case (r_state)
         S_IDLE: if (start) w_state_nxt = S_XFER;
         S_XFER: begin
            if (r_mask == 9'd0) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               mem_addr = r_addr;
               if (!w_is_load) begin
                  mem_write_en = 1'b1;
                  rf_rd_addr   = w_sel_reg;
                  mem_wdata    = rf_rd_data;
               end
               if (w_last) w_state_nxt = w_is_load ? S_DRAIN : S_BASE_WB;
            end
         end
         S_DRAIN: begin
            // LDM that reloads its own base keeps the loaded value
            if (r_base_in_list) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_BASE_WB;
            end
         end
         default: begin
            rf_wr_en    = 1'b1;
            rf_wr_addr  = r_op[1] ? 4'd13 : {1'b0, r_base_reg};
            rf_wr_data  = r_final_base;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef POP_PC_FLUSH_EN
   assign flush_req = r_ld_valid && (r_op == c_op_pop) && (r_ld_idx == 4'd15);
`else
   assign flush_req = 1'b0;
`endif

   assign done = w_done & ~flush_req;

endmodule

`default_nettype wire
